// File: rtl/mc_sram_seq.sv
// mc_sram_seq: single-port async SRAM sequencer with programmable setup, strobe and turnaround timing
module mc_sram_seq #(
    parameter int AW = 18,
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2,
    parameter int TURN = 1
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          mem_stb_i,
    input  logic          mem_we_i,
    input  logic [AW-1:0] mem_addr_i,
    input  logic [15:0]   mem_data_i,
    output logic [15:0]   mem_data_o,
    output logic          mem_ack_o,
    output logic          mem_busy_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [15:0]   sram_dq_o,
    output logic          sram_dq_oe_o,
    input  logic [15:0]   sram_dq_i,
    output logic          sram_ce_n_o,
    output logic          sram_oe_n_o,
    output logic          sram_we_n_o
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_ACK, S_TURN} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            S_IDLE: if (mem_stb_i) begin
                state_n = mem_we_i ? S_WSETUP : S_RD;
                cnt_n = 4'(RD_WAIT - 1);
            end
            S_RD: begin
                state_n = cnt == 4'd0 ? S_ACK : S_RD;
                cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            S_WSETUP: begin
                state_n = S_WPULSE;
                cnt_n = 4'(WR_WAIT - 1);
            end
            S_WPULSE: begin
                state_n = cnt == 4'd0 ? S_WHOLD : S_WPULSE;
                cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            S_WHOLD: state_n = S_ACK;
            S_ACK: begin
                state_n = TURN > 0 ? S_TURN : S_IDLE;
                cnt_n = 4'(TURN - 1);
            end
            S_TURN: begin
                state_n = cnt == 4'd0 ? S_IDLE : S_TURN;
                cnt_n = cnt == 4'd0 ? cnt : cnt - 4'd1;
            end
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
            cnt <= 4'd0;
            mem_data_o <= 16'd0;
            mem_ack_o <= 1'b0;
            mem_busy_o <= 1'b0;
            sram_addr_o <= '0;
            sram_dq_o <= 16'd0;
            sram_dq_oe_o <= 1'b0;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            mem_ack_o <= state_n == S_ACK;
            mem_busy_o <= state_n != S_IDLE;
            sram_ce_n_o <= !(state_n inside {S_RD, S_WSETUP, S_WPULSE, S_WHOLD});
            sram_oe_n_o <= state_n != S_RD;
            sram_we_n_o <= state_n != S_WPULSE;
            sram_dq_oe_o <= state_n inside {S_WSETUP, S_WPULSE, S_WHOLD};
            if (state == S_IDLE && mem_stb_i) begin
                sram_addr_o <= mem_addr_i;
                sram_dq_o <= mem_data_i;
            end
            if (state == S_RD && cnt == 4'd0)
                mem_data_o <= sram_dq_i;
        end
    end
endmodule

// File: tb/tb_mc_sram_seq.sv
// tb_mc_sram_seq: four parameter sets run side by side, each checked cycle by cycle against a transaction-offset model
module tb_mc_sram_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    localparam int RDW [4] = '{2, 2, 2, 1};
    localparam int WRW [4] = '{2, 2, 2, 15};
    localparam int TRN [4] = '{1, 0, 3, 1};
    localparam int RD_LAT [4] = '{3, 3, 3, 2};
    localparam int WR_LAT [4] = '{5, 5, 5, 18};
    localparam int B2B_LAT [4] = '{6, 5, 8, 19};

    task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h expected %0h at %0t", g, nm, act, exp, $time);
        end
    endtask

    for (genvar c = 0; c < 4; c++) begin : g_cfg
        localparam int R = RDW[c];
        localparam int W = WRW[c];
        localparam int T = TRN[c];
        logic rst = 1'b1, stb = 1'b0, we = 1'b0;
        logic [17:0] addr = '0;
        logic [15:0] wdata = '0, dq_in = '0;
        logic [15:0] mdata_o, sdq_o;
        logic [17:0] saddr;
        logic ack, busy, dq_oe, ce_n, oe_n, we_n;
        bit fin = 1'b0;

        mc_sram_seq #(.AW(18), .RD_WAIT(R), .WR_WAIT(W), .TURN(T)) dut (
            .sys_clk(clk), .sys_rst(rst),
            .mem_stb_i(stb), .mem_we_i(we), .mem_addr_i(addr), .mem_data_i(wdata),
            .mem_data_o(mdata_o), .mem_ack_o(ack), .mem_busy_o(busy),
            .sram_addr_o(saddr), .sram_dq_o(sdq_o), .sram_dq_oe_o(dq_oe), .sram_dq_i(dq_in),
            .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
        );

        // model: remember when the current transaction was accepted and derive every output from the cycle offset
        int cyc = 0, t0 = 0;
        bit have = 1'b0;
        logic m_we = 1'b0;
        logic [17:0] m_addr = '0;
        logic [15:0] m_dq = '0, m_data = '0;
        int k, len;
        logic e_act, e_acc;
        assign k = cyc - t0;
        assign len = m_we ? W + 3 : R + 1;
        assign e_act = have && k >= 1 && k <= len + T;
        assign e_acc = have && k >= 1 && k < len;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                have <= 1'b0;
                m_addr <= '0;
                m_dq <= '0;
                m_data <= '0;
                cyc <= 0;
            end else begin
                if (have && !m_we && cyc - t0 == R) m_data <= dq_in;
                if ((!have || cyc - t0 > len + T) && stb) begin
                    have <= 1'b1;
                    t0 <= cyc;
                    m_we <= we;
                    m_addr <= addr;
                    m_dq <= wdata;
                end
                cyc <= cyc + 1;
            end
        end

        always @(negedge clk) begin
            chk(c, "ack", ack, e_act && k == len);
            chk(c, "busy", busy, e_act);
            chk(c, "ce_n", ce_n, !e_acc);
            chk(c, "oe_n", oe_n, !(e_acc && !m_we));
            chk(c, "we_n", we_n, !(e_acc && m_we && k >= 2 && k <= W + 1));
            chk(c, "dq_oe", dq_oe, e_acc && m_we);
            chk(c, "sram_addr", saddr, m_addr);
            chk(c, "sram_dq", sdq_o, m_dq);
            chk(c, "mem_data", mdata_o, m_data);
            chk(c, "oe_dq_overlap", !oe_n && dq_oe, 1'b0);
        end

        task automatic req(input logic w, input logic [17:0] a, input logic [15:0] d, input logic [15:0] q, output int n);
            we = w; addr = a; wdata = d; dq_in = q; stb = 1'b1;
            n = -1;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (ack) begin n = i; break; end
            end
            if (n < 0) begin
                checks++; errors++;
                $display("FAIL cfg%0d ack_timeout: no ack within 60 cycles", c);
            end
            @(posedge clk); #1;
        endtask

        task automatic gap();
            repeat (20) @(posedge clk);
            #1;
        endtask

        initial begin : stim
            int n, nacks;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(posedge clk); #1;
            req(1'b0, 18'h000A5, 16'h0, 16'hBEEF, n);
            stb = 1'b0;
            chk(c, "rd_lat", n, RD_LAT[c]);
            chk(c, "rd_data", mdata_o, 16'hBEEF);
            gap();
            req(1'b1, 18'h01234, 16'hCAFE, 16'h0, n);
            stb = 1'b0;
            chk(c, "wr_lat", n, WR_LAT[c]);
            chk(c, "rd_data_kept", mdata_o, 16'hBEEF);
            gap();
            req(1'b0, 18'h00001, 16'h0, 16'h1111, n);
            req(1'b1, 18'h00002, 16'h2222, 16'h0, n);
            stb = 1'b0;
            chk(c, "b2b_lat", n, B2B_LAT[c]);
            chk(c, "b2b_data", mdata_o, 16'h1111);
            gap();
            we = 1'b0; addr = 18'h00003; dq_in = 16'h3333; stb = 1'b1;
            nacks = 0;
            for (int i = 0; i <= RD_LAT[c] + T; i++) begin
                @(negedge clk);
                nacks += int'(ack);
            end
            @(posedge clk); #1 stb = 1'b0;
            repeat (10) begin
                @(negedge clk);
                nacks += int'(ack);
            end
            chk(c, "held_stb_acks", nacks, 1);
            gap();
            we = 1'b1; addr = 18'h00BAD; wdata = 16'h5555; stb = 1'b1;
            n = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!we_n) begin n = i; break; end
            end
            chk(c, "we_low_cycle", n, 2);
            #1 rst = 1'b1;
            #1;
            chk(c, "rst_we_n", we_n, 1'b1);
            chk(c, "rst_ce_n", ce_n, 1'b1);
            chk(c, "rst_dq_oe", dq_oe, 1'b0);
            chk(c, "rst_busy", busy, 1'b0);
            @(posedge clk); #1;
            rst = 1'b0; stb = 1'b0;
            nacks = 0;
            repeat (10) begin
                @(negedge clk);
                nacks += int'(ack);
            end
            chk(c, "aborted_acks", nacks, 0);
            @(posedge clk); #1;
            req(1'b0, 18'h00077, 16'h0, 16'h7777, n);
            stb = 1'b0;
            chk(c, "post_rst_lat", n, RD_LAT[c]);
            chk(c, "post_rst_data", mdata_o, 16'h7777);
            repeat (5) @(posedge clk);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            if (g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) break;
            @(posedge clk);
        end
        if (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin)) begin
            checks++; errors++;
            $display("FAIL timeout: stimulus did not complete");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_sram_seq.md
# mc_sram_seq

Single-port external SRAM sequencer placed directly downstream of the DDR/memory controller. It takes one already-arbitrated 16-bit request at a time (read or write) and drives the asynchronous SRAM pins with programmable setup, strobe and bus-turnaround timing. It returns read data and a one-cycle acknowledge to the controller. All timing is counted in `sys_clk` cycles; there is no internal queueing.

## Interface
Parameters:
- `AW`, default 18: address width in 16-bit words.
- `RD_WAIT`, default 2: cycles `oe_n` is held low per read; legal range 1..15.
- `WR_WAIT`, default 2: cycles `we_n` is held low per write; legal range 1..15.
- `TURN`, default 1: idle cycles after each access before a new request is accepted; legal range 0..15.

Ports:
- `sys_clk` in 1: the single clock; all logic is rising-edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `mem_stb_i` in 1: request strobe from the controller; held until `mem_ack_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in AW: word address.
- `mem_data_i` in 16: write data.
- `mem_data_o` out 16: registered read data; valid while `mem_ack_o`=1 and held until the next read completes.
- `mem_ack_o` out 1: one-cycle completion pulse.
- `mem_busy_o` out 1: high whenever the state is not IDLE.
- `sram_addr_o` out AW: SRAM address (registered).
- `sram_dq_o` out 16: SRAM write data (registered).
- `sram_dq_oe_o` out 1: tristate enable for `sram_dq_o`.
- `sram_dq_i` in 16: SRAM read data.
- `sram_ce_n_o`, `sram_oe_n_o`, `sram_we_n_o` out 1 each: active-low chip enable, output enable and write enable.

## Operation
- FSM states: IDLE, RD, WSETUP, WPULSE, WHOLD, ACK, TURN. There is one 4-bit down-counter `cnt`.
- **IDLE.** All strobes are inactive.
  - On `mem_stb_i`=1, latch addr, we and data into the `sram_*` registers.
  - Go to RD with `cnt`=RD_WAIT-1, or to WSETUP.
- **RD.** `ce_n`=0, `oe_n`=0, `dq_oe`=0.
  - Each cycle: if `cnt`=0, register `sram_dq_i` into `mem_data_o` and go to ACK; otherwise decrement.
- **WSETUP** (1 cycle). `ce_n`=0, `dq_oe`=1, `we_n`=1. Then go to WPULSE with `cnt`=WR_WAIT-1.
- **WPULSE.** `ce_n`=0, `dq_oe`=1, `we_n`=0. Go to WHOLD when `cnt`=0.
- **WHOLD** (1 cycle). `ce_n`=0, `dq_oe`=1, `we_n`=1. Then go to ACK.
- **ACK** (1 cycle). `mem_ack_o`=1, `ce_n`=1, `oe_n`=1, `we_n`=1, `dq_oe`=0.
  - Go to TURN with `cnt`=TURN-1 if TURN>0, else to IDLE.
- **TURN.** All strobes inactive; `mem_stb_i` is ignored. Go to IDLE when `cnt`=0.
- Address and write data are stable from the first access cycle through WHOLD. Inputs that change after acceptance have no effect.
- `mem_data_o` is not modified by writes.
- Control outputs are decoded from registered state only, so no combinational path exists from `mem_*` inputs to `sram_*` outputs.
- **Back-to-back.** With TURN=0, `mem_stb_i`=1 in the cycle after ack (IDLE) is a new request.
  - The requester must deassert `mem_stb_i` or present the next request in that cycle.
- **Reset.** On `sys_rst` the block returns to IDLE immediately (asynchronously), including mid-access. Reset values:
  - `mem_ack_o`=0, `mem_busy_o`=0, `mem_data_o`=0.
  - `sram_addr_o`=0, `sram_dq_o`=0, `sram_dq_oe_o`=0.
  - `sram_ce_n_o`=1, `sram_oe_n_o`=1, `sram_we_n_o`=1.
  - An aborted access produces no ack.

## Timing
- Request is sampled in IDLE at cycle 0.
- Read: `oe_n` is low for cycles 1..RD_WAIT. Data is sampled at the end of cycle RD_WAIT; ack and data are at cycle RD_WAIT+1. Latency = RD_WAIT+1.
- Write: setup at cycle 1; `we_n` low for cycles 2..WR_WAIT+1; hold at cycle WR_WAIT+2; ack at WR_WAIT+3. Latency = WR_WAIT+3.
- Earliest next acceptance is cycle ack+1+TURN.
- `sram_dq_oe_o` never overlaps `sram_oe_n_o`=0, and at least one strobe-inactive (ACK) cycle separates any read from a following write.

## Test plan
- **Read, defaults.** `mem_stb_i`=1, we=0, addr=0x00A5, `sram_dq_i`=0xBEEF:
  - `sram_addr_o`=0x00A5 and `oe_n`=0 in cycles 1–2.
  - Ack in cycle 3 with `mem_data_o`=0xBEEF; TURN in cycle 4; IDLE in cycle 5.
- **Write, defaults.** Addr=0x1234, data=0xCAFE:
  - `dq_oe`=1 in cycles 1–4 with `sram_dq_o`=0xCAFE.
  - `we_n`=0 only in cycles 2–3; ack in cycle 5; `mem_data_o` unchanged.
- **Back-to-back, TURN=0.** Read 0x0001 then write 0x0002:
  - Second request accepted in the cycle after the first ack.
  - No cycle has `oe_n`=0 and `dq_oe`=1 together.
- **Strobe during busy.** Keep `mem_stb_i` high through ACK and TURN with TURN=3:
  - No second access starts before IDLE.
  - Exactly one ack is issued per accepted request.
- **Reset mid-write.** Assert `sys_rst` during WPULSE:
  - Same cycle: `we_n`=1, `ce_n`=1, `dq_oe`=0, `busy`=0.
  - No ack; the next read after reset completes normally.
- **Parameter corner.** RD_WAIT=1, WR_WAIT=15:
  - Read ack at cycle 2.
  - Write `we_n` low for exactly 15 cycles, ack at cycle 18.
